// File: rtl/reflex_pkg.sv
// Shared types and constants for the reflex_ctrl reaction-time sequencer.
package reflex_pkg;

    localparam int RESULT_W = 13;
    localparam logic [RESULT_W-1:0] BEST_INIT = 13'd8191;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        ARMED = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/reflex_if.sv
// Handshake and result bundle between reflex_ctrl and its stimulus/display side.
// Optional macro: BEST_TIME_EN adds the best_ms result.
interface reflex_if;
    import reflex_pkg::*;

    logic                start;
    logic                button;
    logic                led;
    logic                busy;
    logic                result_valid;
    logic [RESULT_W-1:0] result_ms;
    logic                timeout;
    logic                false_start;
`ifdef BEST_TIME_EN
    logic [RESULT_W-1:0] best_ms;
`endif

`ifdef BEST_TIME_EN
    modport master (output start, button,
                    input  led, busy, result_valid, result_ms, timeout, false_start, best_ms);
    modport slave  (input  start, button,
                    output led, busy, result_valid, result_ms, timeout, false_start, best_ms);
`else
    modport master (output start, button,
                    input  led, busy, result_valid, result_ms, timeout, false_start);
    modport slave  (input  start, button,
                    output led, busy, result_valid, result_ms, timeout, false_start);
`endif

endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV enabled cycles.
module ms_tick_gen #(
    parameter int TICK_DIV = 100_000
) (
    input  logic ck,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    // Clear has priority so a new phase always starts a full tick period.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + PW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/reflex_ctrl.sv
// Reaction-time trial sequencer: pre-delay, LED stimulus, ms measurement.
// Optional macro: BEST_TIME_EN keeps the best valid result in best_ms.
//
// state | meaning
// IDLE  | waiting for first start after reset
// DELAY | pre-delay running, LED off, a press here is a false start
// ARMED | LED on, counting ms until press or timeout
// DONE  | result held until the next start
module reflex_ctrl
    import reflex_pkg::*;
#(
    parameter int TICK_DIV   = 100_000,
    parameter int DELAY_MS   = 2000,
    parameter int TIMEOUT_MS = 5000
) (
    input  logic    ck,
    input  logic    reset_n,
    reflex_if.slave bus
);

    localparam logic [RESULT_W-1:0] DELAY_LAST   = RESULT_W'(DELAY_MS - 1);
    localparam logic [RESULT_W-1:0] TIMEOUT_LAST = RESULT_W'(TIMEOUT_MS - 1);
    localparam logic [RESULT_W-1:0] TIMEOUT_VAL  = RESULT_W'(TIMEOUT_MS);

    state_t              state_q, state_d;
    logic [RESULT_W-1:0] ms_cnt_q, ms_cnt_d;
    logic [RESULT_W-1:0] result_ms_q, result_ms_d;
    logic                result_valid_q, result_valid_d;
    logic                timeout_q, timeout_d;
    logic                false_start_q, false_start_d;
    logic                led_q, led_d;
    logic                busy_q, busy_d;
    logic                tick, tick_en, tick_clr;
`ifdef BEST_TIME_EN
    logic [RESULT_W-1:0] best_ms_q, best_ms_d;
`endif

    assign tick_en  = (state_q == DELAY) || (state_q == ARMED);
    assign tick_clr = (state_d != state_q) && ((state_d == DELAY) || (state_d == ARMED));

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .ck      (ck),
        .reset_n (reset_n),
        .clr     (tick_clr),
        .en      (tick_en),
        .tick    (tick)
    );

    // Next state, ms counter and result capture; button is checked before tick so it wins ties.
    always_comb begin
        state_d        = state_q;
        ms_cnt_d       = ms_cnt_q;
        result_ms_d    = result_ms_q;
        result_valid_d = result_valid_q;
        timeout_d      = timeout_q;
        false_start_d  = false_start_q;
`ifdef BEST_TIME_EN
        best_ms_d      = best_ms_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = DELAY;
            end
            DELAY: begin
                if (bus.button) begin
                    state_d       = DONE;
                    false_start_d = 1'b1;
                    result_ms_d   = '0;
                end else if (tick && (ms_cnt_q == DELAY_LAST)) begin
                    state_d = ARMED;
                end else if (tick) begin
                    ms_cnt_d = ms_cnt_q + RESULT_W'(1);
                end
            end
            ARMED: begin
                if (bus.button) begin
                    state_d        = DONE;
                    result_valid_d = 1'b1;
                    result_ms_d    = ms_cnt_q;
`ifdef BEST_TIME_EN
                    if (ms_cnt_q < best_ms_q) best_ms_d = ms_cnt_q;
`endif
                end else if (tick && (ms_cnt_q == TIMEOUT_LAST)) begin
                    state_d     = DONE;
                    timeout_d   = 1'b1;
                    result_ms_d = TIMEOUT_VAL;
                end else if (tick) begin
                    ms_cnt_d = ms_cnt_q + RESULT_W'(1);
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d        = DELAY;
                    result_valid_d = 1'b0;
                    timeout_d      = 1'b0;
                    false_start_d  = 1'b0;
                    result_ms_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (tick_clr) ms_cnt_d = '0;
        led_d  = (state_d == ARMED);
        busy_d = (state_d == DELAY) || (state_d == ARMED);
    end

    // State, counter and registered outputs.
    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            ms_cnt_q       <= '0;
            result_ms_q    <= '0;
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            false_start_q  <= 1'b0;
            led_q          <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ms_cnt_q       <= ms_cnt_d;
            result_ms_q    <= result_ms_d;
            result_valid_q <= result_valid_d;
            timeout_q      <= timeout_d;
            false_start_q  <= false_start_d;
            led_q          <= led_d;
            busy_q         <= busy_d;
        end
    end

`ifdef BEST_TIME_EN
    // Best valid time survives trials; only reset restores it.
    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) best_ms_q <= BEST_INIT;
        else          best_ms_q <= best_ms_d;
    end
    assign bus.best_ms = best_ms_q;
`endif

    assign bus.led          = led_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_ms    = result_ms_q;
    assign bus.timeout      = timeout_q;
    assign bus.false_start  = false_start_q;

endmodule
